// File: rtl/edge_pkg.sv
// Types and constants shared by the edge-pipeline output stage.
package edge_pkg;

    localparam logic [7:0] STOPBYTE = 8'h12;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        STOP,
        DONE
    } oseq_state_t;

endpackage

// File: rtl/pixel_counter.sv
// Column/row position of the next pixel, wrapping at the frame end.
// Latency: one cycle from inc to updated col/row; last is combinational from position.
// Backpressure: none; advances only when inc is high.
module pixel_counter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic                     last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/output_sequencer.sv
// Frame controller: paces pixels into the output register, then a run of STOPBYTE beats.
// Latency: out_valid is one cycle after the issue; frame_start to first beat is two cycles.
// Backpressure: out_ready at t grants a beat at t+1; no skid buffer.
module output_sequencer
    import edge_pkg::*;
#(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int STOP_LEN = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic                     overflow,
    input  logic                     underflow,
    input  logic                     out_ready,
    output logic                     data_select,
    output logic                     out_valid,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic [CNT_W-1:0]         unf_cnt,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int SW = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
    localparam logic [SW-1:0] STOP_MAX = SW'(STOP_LEN - 1);

    oseq_state_t   state, state_nxt;
    logic          issue;
    logic          clr_frame;
    logic          last_pix;
    logic [SW-1:0] stop_cnt;

    pixel_counter #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) u_pixel_counter (
        .clk (clk),
        .rst (rst),
        .clr (clr_frame),
        .inc (pix_ready),
        .col (col),
        .row (row),
        .last(last_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        data_select = 1'b0;
        pix_ready   = 1'b0;
        issue       = 1'b0;
        frame_done  = 1'b0;
        clr_frame   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    clr_frame = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                data_select = 1'b1;
                pix_ready   = pix_valid & out_ready;
                issue       = pix_ready;
                if (pix_ready && last_pix) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                issue = out_ready;
                if (out_ready && (stop_cnt == STOP_MAX)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // The output register latches on the issue, so its valid lags by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state != STOP)) begin
            stop_cnt <= '0;
        end else if (out_ready) begin
            stop_cnt <= stop_cnt + 1'b1;
        end
    end

    // Counts hold after the frame so they can be read at and after frame_done.
    always_ff @(posedge clk) begin
        if (rst || clr_frame) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else if (pix_ready) begin
            if (overflow && !(&ovf_cnt)) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
            if (underflow && !(&unf_cnt)) begin
                unf_cnt <= unf_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_sequencer.sv
// Bench for output_sequencer: a count-based frame model predicts every output each cycle.
module tb_output_sequencer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int SL   = 2;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic pix_valid = 1'b0;
    logic overflow = 1'b0;
    logic underflow = 1'b0;
    logic out_ready = 1'b0;

    logic        pix_ready, data_select, out_valid, busy, frame_done;
    logic [1:0]  col;
    logic        row;
    logic [15:0] ovf_cnt, unf_cnt;

    logic        s_pix_ready, s_data_select, s_out_valid, s_busy, s_frame_done;
    logic [1:0]  s_col;
    logic        s_row;
    logic [1:0]  s_ovf_cnt, s_unf_cnt;

    always #5 clk = ~clk;

    output_sequencer #(.IMG_W(W), .IMG_H(H), .STOP_LEN(SL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .overflow(overflow), .underflow(underflow),
        .out_ready(out_ready), .data_select(data_select), .out_valid(out_valid),
        .col(col), .row(row), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt),
        .busy(busy), .frame_done(frame_done)
    );

    output_sequencer #(.IMG_W(W), .IMG_H(H), .STOP_LEN(SL), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_ready(s_pix_ready), .overflow(overflow), .underflow(underflow),
        .out_ready(out_ready), .data_select(s_data_select), .out_valid(s_out_valid),
        .col(s_col), .row(s_row), .ovf_cnt(s_ovf_cnt), .unf_cnt(s_unf_cnt),
        .busy(s_busy), .frame_done(s_frame_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: frame activity plus pixel/STOP beat tallies.
    bit m_active;
    int m_pix, m_stop, m_ovf, m_unf;
    bit m_ov_exp;

    // Per-frame observations.
    int obs_beats, obs_pix, obs_done, first_ov, last_ov;
    int done_ovf, done_unf, done_sovf;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic step(input bit r, input bit fs, input bit pv, input bit ordy,
                        input bit ov, input bit un);
        bit stream, stopp, donep, iss;
        logic [4:0]  exp_v, obs_v;
        logic [1:0]  exp_col;
        logic        exp_row;
        logic [15:0] exp_ovf, exp_unf;
        logic [1:0]  exp_sovf, exp_sunf;
        rst = r; frame_start = fs; pix_valid = pv; out_ready = ordy;
        overflow = ov; underflow = un;
        #1;
        stream   = m_active && (m_pix < NPIX);
        stopp    = m_active && (m_pix == NPIX) && (m_stop < SL);
        donep    = m_active && (m_stop == SL);
        exp_v    = {stream && pv && ordy, stream, m_active, donep, m_ov_exp};
        obs_v    = {pix_ready, data_select, busy, frame_done, out_valid};
        exp_col  = 2'(m_pix % W);
        exp_row  = 1'((m_pix / W) % H);
        exp_ovf  = 16'(sat(m_ovf, 16));
        exp_unf  = 16'(sat(m_unf, 16));
        exp_sovf = 2'(sat(m_ovf, 2));
        exp_sunf = 2'(sat(m_unf, 2));
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL ctrl cyc=%0d {rdy,sel,busy,done,oval} got %b want %b", cyc, obs_v, exp_v);
        end
        checks++;
        if ({col, row} !== {exp_col, exp_row}) begin
            errors++;
            $display("FAIL position cyc=%0d col/row got %0d/%0d want %0d/%0d", cyc, col, row, exp_col, exp_row);
        end
        checks++;
        if ({ovf_cnt, unf_cnt} !== {exp_ovf, exp_unf}) begin
            errors++;
            $display("FAIL err_cnt cyc=%0d ovf/unf got %0d/%0d want %0d/%0d", cyc, ovf_cnt, unf_cnt, exp_ovf, exp_unf);
        end
        checks++;
        if ({s_ovf_cnt, s_unf_cnt} !== {exp_sovf, exp_sunf}) begin
            errors++;
            $display("FAIL sat_cnt cyc=%0d ovf/unf got %0d/%0d want %0d/%0d", cyc, s_ovf_cnt, s_unf_cnt, exp_sovf, exp_sunf);
        end
        if (out_valid === 1'b1) begin
            obs_beats++;
            if (first_ov < 0) first_ov = cyc;
            last_ov = cyc;
        end
        if (pix_ready === 1'b1) obs_pix++;
        if (frame_done === 1'b1) begin
            obs_done++;
            done_ovf  = int'(ovf_cnt);
            done_unf  = int'(unf_cnt);
            done_sovf = int'(s_ovf_cnt);
        end
        iss = 1'b0;
        if (r) begin
            m_active = 1'b0; m_pix = 0; m_stop = 0; m_ovf = 0; m_unf = 0;
        end else if (!m_active) begin
            if (fs) begin
                m_active = 1'b1; m_pix = 0; m_stop = 0; m_ovf = 0; m_unf = 0;
            end
        end else if (stream) begin
            iss = pv && ordy;
            if (iss) begin
                m_pix++;
                m_ovf += int'(ov);
                m_unf += int'(un);
            end
        end else if (stopp) begin
            iss = ordy;
            if (iss) m_stop++;
        end else begin
            m_active = 1'b0;
        end
        m_ov_exp = iss;
        cyc++;
        @(negedge clk);
    endtask

    // Starts a frame and drives it to frame_done with a scenario-specific stimulus.
    task automatic drive_frame(input int mode, output bit timed_out, output int start_cyc);
        int k;
        bit pv, ordy, ov, un, fs;
        obs_beats = 0; obs_pix = 0; obs_done = 0; first_ov = -1; last_ov = -1;
        done_ovf = -1; done_unf = -1; done_sovf = -1;
        start_cyc = cyc;
        step(0, 1, 1, 1, 0, 0);
        k = 0;
        while (obs_done == 0 && k < 200) begin
            pv = 1'b1; ordy = 1'b1; ov = 1'b0; un = 1'b0; fs = 1'b0;
            case (mode)
                1: ordy = (k % 2 == 0);
                2: begin
                    ov = (m_pix == 2) || (m_pix == 6);
                    un = (m_pix == 5) || (m_pix == 6);
                end
                3: ov = (m_pix < 5);
                4: fs = (k == 3) || (m_active && m_stop == SL);
                5: pv = !(k >= 2 && k < 7);
                6: begin
                    pv   = ($urandom_range(0, 3) != 0);
                    ordy = ($urandom_range(0, 3) != 0);
                    ov   = 1'($urandom_range(0, 1));
                    un   = 1'($urandom_range(0, 1));
                    fs   = ($urandom_range(0, 7) == 0);
                end
                default: ;
            endcase
            step(0, fs, pv, ordy, ov, un);
            k++;
        end
        timed_out = (obs_done == 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_frame_shape(input string name, input bit timed_out);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL %s timeout: no frame_done within budget", name);
        end
        checks++;
        if (obs_pix != NPIX || obs_beats != NPIX + SL || obs_done != 1) begin
            errors++;
            $display("FAIL %s shape pix/beats/done got %0d/%0d/%0d want %0d/%0d/1",
                     name, obs_pix, obs_beats, obs_done, NPIX, NPIX + SL);
        end
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 1);
        checks++;
        if ({busy, out_valid, data_select, pix_ready, col, row, ovf_cnt} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b oval=%b sel=%b rdy=%b col=%0d row=%0d ovf=%0d want all 0",
                     busy, out_valid, data_select, pix_ready, col, row, ovf_cnt);
        end
    endtask

    task automatic test_nominal();
        bit to; int st;
        drive_frame(0, to, st);
        check_frame_shape("nominal", to);
        checks++;
        if (first_ov - st != 2 || last_ov - first_ov != NPIX + SL - 1) begin
            errors++;
            $display("FAIL nominal_timing first/last out_valid offset got %0d/%0d want 2/%0d",
                     first_ov - st, last_ov - st, NPIX + SL + 1);
        end
    endtask

    task automatic test_backpressure();
        bit to; int st;
        drive_frame(1, to, st);
        check_frame_shape("backpressure", to);
    endtask

    task automatic test_errors();
        bit to; int st;
        drive_frame(2, to, st);
        check_frame_shape("errors", to);
        checks++;
        if (done_ovf != 2 || done_unf != 2) begin
            errors++;
            $display("FAIL errors_at_done ovf/unf got %0d/%0d want 2/2", done_ovf, done_unf);
        end
    endtask

    task automatic test_saturation();
        bit to; int st;
        drive_frame(3, to, st);
        check_frame_shape("saturation", to);
        checks++;
        if (done_sovf != 3 || done_ovf != 5) begin
            errors++;
            $display("FAIL saturation ovf(2b)/ovf(16b) got %0d/%0d want 3/5", done_sovf, done_ovf);
        end
    endtask

    task automatic test_spurious_start();
        bit to; int st;
        drive_frame(4, to, st);
        check_frame_shape("spurious", to);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to; int st; int k;
        obs_done = 0;
        step(0, 1, 1, 1, 0, 0);
        k = 0;
        while (m_pix < 3 && k < 20) begin
            step(0, 0, 1, 1, 0, 0);
            k++;
        end
        step(1, 0, 1, 1, 0, 0);
        checks++;
        if ({busy, out_valid, col, row} !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid busy/oval/col/row got %b/%b/%0d/%0d want 0/0/0/0", busy, out_valid, col, row);
        end
        repeat (6) step(0, 0, 1, 1, 0, 0);
        checks++;
        if (obs_done != 0) begin
            errors++;
            $display("FAIL reset_mid_done frame_done pulses got %0d want 0", obs_done);
        end
        drive_frame(0, to, st);
        check_frame_shape("reset_restart", to);
    endtask

    task automatic test_starvation();
        bit to; int st;
        drive_frame(5, to, st);
        check_frame_shape("starvation", to);
    endtask

    task automatic test_random();
        bit to; int st;
        for (int f = 0; f < 6; f++) begin
            drive_frame(6, to, st);
            check_frame_shape("random", to);
            checks++;
            if (done_ovf != m_ovf || done_unf != m_unf) begin
                errors++;
                $display("FAIL random_err frame %0d ovf/unf got %0d/%0d want %0d/%0d",
                         f, done_ovf, done_unf, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        m_active = 1'b0; m_pix = 0; m_stop = 0; m_ovf = 0; m_unf = 0; m_ov_exp = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_errors();
        test_saturation();
        test_spurious_start();
        test_reset_mid_frame();
        test_starvation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_sequencer.md
# output_sequencer

Frame-level controller for the edge-pipeline output register stage. It waits for a frame start, then paces pixels from the arithmetic stage into the output register. After the last pixel it forces a programmable run of STOPBYTE beats, then pulses frame completion. It drives the output stage's `data_select`, qualifies the registered output with `out_valid`, and keeps per-frame overflow and underflow counts.

## Interface
Parameters:
- `IMG_W`, default 640: pixels per row.
- `IMG_H`, default 480: rows per frame.
- `STOP_LEN`, default 1: STOPBYTE beats emitted per frame end (≥1).
- `CNT_W`, default 16: width of the saturating error counters.

Ports:
- `clk`  in  1  single system clock; everything is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `frame_start`  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- `pix_valid`  in  1  arithmetic stage has a pixel (arith_out, overflow, underflow) stable.
- `pix_ready`  out  1  pixel accepted this cycle.
- `overflow`, `underflow`  in  1  error flags of the presented pixel.
- `out_ready`  in  1  downstream credit; high at cycle t permits a beat at t+1.
- `data_select`  out  1  output stage select: 1 = pixel path, 0 = STOPBYTE.
- `out_valid`  out  1  output stage register holds a new beat this cycle.
- `col`  out  $clog2(IMG_W)  column of the next pixel.
- `row`  out  $clog2(IMG_H)  row of the next pixel.
- `ovf_cnt`, `unf_cnt`  out  CNT_W  per-frame error counts (saturating).
- `busy`  out  1  high when the state is not IDLE.
- `frame_done`  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE → STREAM → STOP → DONE → IDLE.
- **IDLE**
  - `data_select`=0; `pix_ready`=0.
  - `frame_start` clears `col`, `row`, `ovf_cnt`, `unf_cnt` and sets the state to STREAM.
- **STREAM**
  - `data_select`=1; `pix_ready = pix_valid & out_ready` (combinational).
  - An accepted pixel is an issue.
  - On an issue, `col` increments. At `IMG_W-1`, `col` wraps to 0 and `row` increments.
  - On an issue with `overflow`, `ovf_cnt` increments. On an issue with `underflow`, `unf_cnt` increments. Both saturate at all-ones.
  - If `overflow` and `underflow` are both high, both counters increment.
  - Issuing the pixel at `col=IMG_W-1`, `row=IMG_H-1` wraps both counters to 0 and sets the state to STOP.
- **STOP**
  - `data_select`=0; `pix_ready`=0.
  - Each cycle with `out_ready` is an issue.
  - After `STOP_LEN` issues the state becomes DONE. The STOP beat count uses a dedicated counter.
- **DONE**
  - `frame_done`=1 for this one cycle; the state then becomes IDLE.
- `frame_start` outside IDLE is ignored, including in the DONE cycle.
- `busy` is high in STREAM, STOP and DONE.

## Timing
- `out_valid` is registered: `out_valid(t+1) = issue(t)`. This matches the output stage's one-cycle register latency.
- `data_select` is combinational from state, so it is valid in the same cycle as the issue.
- Downstream absorbs any beat it granted with `out_ready`. No skid buffer is provided.
- Throughput is one beat per cycle.
- Frame length is `IMG_W*IMG_H + STOP_LEN` beats. Add one DONE cycle before IDLE.
- The first STOP beat may issue in the cycle immediately after the last pixel issue.
- Reset values: state IDLE; `data_select`=0; `pix_ready`=0; `out_valid`=0; `col`=0; `row`=0; `ovf_cnt`=0; `unf_cnt`=0; `busy`=0; `frame_done`=0.
- `rst` mid-frame aborts the frame: no STOP beats and no `frame_done`.
- `rst` has priority over every other input.

## Structure
- Shared package `edge_pkg` holds:
  - `STOPBYTE` = 8'h12.
  - State enum `oseq_state_t` {IDLE, STREAM, STOP, DONE}.
- Sub-module `pixel_counter` implements the col/row wrap counter:
  - parameters `IMG_W`, `IMG_H`; inputs `clr`, `inc`; outputs `col`, `row`, `last`.
- FSM, STOP counter and error counters are in the top module.

## Test plan
Bench parameters: IMG_W=4, IMG_H=2, STOP_LEN=2.
- **Nominal frame.** Reset, then `frame_start`, `pix_valid`=1, `out_ready`=1. Expect:
  - 8 beats with `data_select`=1, then 2 with `data_select`=0.
  - `out_valid` high for 10 consecutive cycles, starting 2 cycles after `frame_start`.
  - `frame_done` pulses once; `busy` falls with it.
- **Backpressure.** Toggle `out_ready` 1,0,1,0… Expect:
  - Beats only on cycles after `out_ready`=1.
  - `col` holds while `out_ready`=0.
  - Still exactly 8 pixel and 2 STOP beats.
- **Errors.** Pixel 2 has `overflow`; pixel 5 has `underflow`; pixel 6 has both. Expect `ovf_cnt`=2 and `unf_cnt`=2 at `frame_done`. With CNT_W=2, 5 overflows saturate `ovf_cnt` at 3.
- **Spurious start.** Pulse `frame_start` mid-STREAM and again on the `frame_done` cycle. Expect no effect: counters continue and the state returns to IDLE.
- **Reset mid-frame.** Assert `rst` after pixel 3. Next cycle expect IDLE, `out_valid`=0, `col`=0, `row`=0, and no `frame_done`. A new `frame_start` then runs a full 8+2 frame.
- **Upstream starvation.** Hold `pix_valid`=0 for 5 cycles in STREAM. Expect `pix_ready`=0, no `out_valid`, and `data_select` held at 1.
